// File: rtl/idli_sqi_arb_m.sv
// SQI arbiter: shares one SQI controller between fetch (read-only) and load/store.
// Requests that continue the open stream (same direction, next word address) are
// granted without restarting the transaction; anything else closes the stream.
module idli_sqi_arb_m #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_fe_req,
  input  logic [ADDR_W-1:0] i_fe_addr,
  output logic              o_fe_gnt,
  output logic              o_fe_done,
  input  logic              i_ls_req,
  input  logic              i_ls_wr,
  input  logic [ADDR_W-1:0] i_ls_addr,
  output logic              o_ls_gnt,
  output logic              o_ls_done,
  output logic              o_ctl_start,
  output logic              o_ctl_wr,
  output logic [ADDR_W-1:0] o_ctl_addr,
  output logic              o_ctl_stop,
  output logic              o_ctl_owner,
  input  logic              i_ctl_rdy,
  input  logic              i_ctl_beat
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-2:0] strm_q, strm_d;    // next stream word address (byte addr >> 1)
  logic              wr_q, wr_d;
  logic              owner_q, owner_d;
  logic              slot_vld_q, slot_vld_d;
  logic              slot_own_q, slot_own_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              fe_done_q, fe_done_d;
  logic              ls_done_q, ls_done_d;

  logic              starved, fe_win, ls_win, any_req, win_wr, win_hit;
  logic [ADDR_W-2:0] win_hi;
  logic [ADDR_W-1:0] win_base;
  logic              gnt, start, stop;
  logic              unused_addr_lsb;

  // Byte-address bit 0 carries no information for word accesses.
  assign unused_addr_lsb = i_fe_addr[0] ^ i_ls_addr[0];

  // LS has priority unless FE has been passed over STARVE_MAX times in a row.
  assign starved  = (starve_q == CntW'(STARVE_MAX));
  assign fe_win   = i_fe_req && (!i_ls_req || starved);
  assign ls_win   = i_ls_req && !fe_win;
  assign any_req  = fe_win || ls_win;
  assign win_wr   = ls_win && i_ls_wr;
  assign win_hi   = ls_win ? i_ls_addr[ADDR_W-1:1] : i_fe_addr[ADDR_W-1:1];
  assign win_base = {win_hi, 1'b0};
  assign win_hit  = (win_wr == wr_q) && (win_hi == strm_q);

  // Next-state, grant and controller sequencing.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    strm_d     = strm_q;
    wr_d       = wr_q;
    owner_d    = owner_q;
    slot_vld_d = slot_vld_q;
    slot_own_d = slot_own_q;
    starve_d   = starve_q;
    fe_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    gnt        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Reset gating keeps the combinational grant/start low while in reset.
        if (i_sqi_rst_n && i_ctl_rdy && any_req) begin
          gnt     = 1'b1;
          start   = 1'b1;
          addr_d  = win_base;
          wr_d    = win_wr;
          owner_d = ls_win;
          strm_d  = win_hi + 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // A miss by the winner blocks the loser too, so the stream closes.
        if (!slot_vld_q && any_req && win_hit) begin
          gnt        = 1'b1;
          slot_vld_d = 1'b1;
          slot_own_d = ls_win;
          strm_d     = strm_q + 1'b1;
        end
        // The beat sees this cycle's grant, so a same-cycle hit keeps the stream open.
        if (i_ctl_beat) begin
          fe_done_d = !owner_q;
          ls_done_d = owner_q;
          if (slot_vld_d) begin
            owner_d    = slot_own_d;
            slot_vld_d = 1'b0;
          end else begin
            stop    = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (i_ctl_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (gnt) begin
      if (ls_win && i_fe_req) starve_d = starve_q + 1'b1;
      else                    starve_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      strm_q     <= '0;
      wr_q       <= 1'b0;
      owner_q    <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_own_q <= 1'b0;
      starve_q   <= '0;
      fe_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      strm_q     <= strm_d;
      wr_q       <= wr_d;
      owner_q    <= owner_d;
      slot_vld_q <= slot_vld_d;
      slot_own_q <= slot_own_d;
      starve_q   <= starve_d;
      fe_done_q  <= fe_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  assign o_fe_gnt    = gnt && fe_win;
  assign o_ls_gnt    = gnt && ls_win;
  assign o_fe_done   = fe_done_q;
  assign o_ls_done   = ls_done_q;
  assign o_ctl_start = start;
  assign o_ctl_stop  = stop;
  assign o_ctl_wr    = start ? win_wr : wr_q;
  assign o_ctl_addr  = start ? win_base : addr_q;
  assign o_ctl_owner = owner_q;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Bench for idli_sqi_arb_m: behavioural SQI controller, queue-fed requesters and a
// done-order scoreboard, with one task per scenario.
module tb_idli_sqi_arb_m;

  localparam int unsigned AW  = 16;
  localparam int          PRE = 2;  // controller preamble cycles after start
  localparam int          GAP = 1;  // idle cycles between beats
  localparam int          DRN = 2;  // controller recovery cycles after stop

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fe_req, ls_req, ls_wr;
  logic [AW-1:0] fe_addr, ls_addr;
  logic          fe_gnt, fe_done, ls_gnt, ls_done;
  logic          ctl_start, ctl_wr, ctl_stop, ctl_owner;
  logic [AW-1:0] ctl_addr;
  logic          ctl_rdy, ctl_beat;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] fe_q[$];
  logic [AW:0]   ls_q[$];   // {wr, addr}
  logic          exp_q[$];  // expected done owner, in grant order

  int            start_cnt = 0, stop_cnt = 0, fe_done_cnt = 0, ls_done_cnt = 0;
  int            tx_beats = 0, beats_at_stop = 0;
  logic [AW-1:0] last_start_addr = '0;
  logic          last_start_wr = 1'b0;
  int            cst = 0;

  always #5 clk = ~clk;

  idli_sqi_arb_m #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst_n (rst_n),
    .i_fe_req    (fe_req),
    .i_fe_addr   (fe_addr),
    .o_fe_gnt    (fe_gnt),
    .o_fe_done   (fe_done),
    .i_ls_req    (ls_req),
    .i_ls_wr     (ls_wr),
    .i_ls_addr   (ls_addr),
    .o_ls_gnt    (ls_gnt),
    .o_ls_done   (ls_done),
    .o_ctl_start (ctl_start),
    .o_ctl_wr    (ctl_wr),
    .o_ctl_addr  (ctl_addr),
    .o_ctl_stop  (ctl_stop),
    .o_ctl_owner (ctl_owner),
    .i_ctl_rdy   (ctl_rdy),
    .i_ctl_beat  (ctl_beat)
  );

  // Controller model: preamble after start, a beat every GAP+1 cycles, recovery after stop.
  initial begin : ctl_model
    bit s, p;
    int cnt;
    ctl_rdy = 1'b1; ctl_beat = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      s = ctl_start; p = ctl_stop;
      @(posedge clk); #1;
      ctl_beat = 1'b0;
      if (!rst_n) begin
        cst = 0; ctl_rdy = 1'b1;
      end else begin
        case (cst)
          0: if (s) begin cst = 1; ctl_rdy = 1'b0; cnt = PRE; end
          1: begin
            if (p) begin cst = 2; cnt = DRN; end
            else if (cnt == 0) begin ctl_beat = 1'b1; cnt = GAP; end
            else cnt--;
          end
          default: begin
            if (cnt == 0) begin cst = 0; ctl_rdy = 1'b1; end
            else cnt--;
          end
        endcase
      end
    end
  end

  // Requesters: present queue heads, retire them the cycle after their grant.
  initial begin : req_model
    bit fg, lg;
    fe_req = 1'b0; fe_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0;
    forever begin
      @(negedge clk);
      fg = fe_gnt; lg = ls_gnt;
      @(posedge clk); #1;
      if (fg && fe_q.size() > 0) begin void'(fe_q.pop_front()); exp_q.push_back(1'b0); end
      if (lg && ls_q.size() > 0) begin void'(ls_q.pop_front()); exp_q.push_back(1'b1); end
      fe_req  = (fe_q.size() > 0);
      fe_addr = fe_req ? fe_q[0] : '0;
      ls_req  = (ls_q.size() > 0);
      ls_wr   = ls_req ? ls_q[0][AW] : 1'b0;
      ls_addr = ls_req ? ls_q[0][AW-1:0] : '0;
    end
  end

  // Scoreboard and event counters.
  initial begin : monitor
    logic e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fe_done || ls_done) begin
          checks++;
          if (fe_done && ls_done) begin
            failures++; $display("FAIL done_both: fe=%0b ls=%0b required one-hot", fe_done, ls_done);
          end else if (exp_q.size() == 0) begin
            failures++; $display("FAIL done_unexpected: ls_done=%0b with no grant outstanding", ls_done);
          end else begin
            e = exp_q.pop_front();
            if (ls_done !== e) begin
              failures++; $display("FAIL done_owner: got ls_done=%0b required %0b", ls_done, e);
            end
          end
        end
        if (fe_gnt || ls_gnt) begin
          checks++;
          if (fe_gnt && ls_gnt) begin
            failures++; $display("FAIL one_gnt: fe_gnt=%0b ls_gnt=%0b", fe_gnt, ls_gnt);
          end
        end
        if (ctl_start) begin
          start_cnt++; last_start_addr = ctl_addr; last_start_wr = ctl_wr; tx_beats = 0;
        end
        if (ctl_beat) begin
          tx_beats++;
          checks++;
          if (dut.state_q != 2'd1) begin
            failures++; $display("FAIL beat_state: beat seen in state %0d required BUSY(1)", dut.state_q);
          end
        end
        if (ctl_stop) begin stop_cnt++; beats_at_stop = tx_beats; end
        if (fe_done) fe_done_cnt++;
        if (ls_done) ls_done_cnt++;
      end
    end
  end

  task automatic wait_quiet(input int budget, output bit ok);
    int stable;
    stable = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fe_q.size() == 0 && ls_q.size() == 0 && !fe_req && !ls_req &&
          exp_q.size() == 0 && cst == 0) stable++;
      else stable = 0;
      if (stable >= 3) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fe_gnt, fe_done, ls_gnt, ls_done, ctl_start, ctl_wr, ctl_stop, ctl_owner, ctl_addr} !== '0) begin
      failures++; $display("FAIL reset_outputs: got addr=%h start=%0b stop=%0b required all 0",
                           ctl_addr, ctl_start, ctl_stop);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({fe_gnt, ls_gnt, ctl_start, ctl_stop, ctl_owner} !== '0 || ctl_addr !== '0) begin
      failures++; $display("FAIL idle_after_reset: gnt=%0b/%0b start=%0b required 0", fe_gnt, ls_gnt, ctl_start);
    end
  endtask

  task automatic test_cold_fetch();
    int s0, p0, d0;
    bit seen, ok;
    s0 = start_cnt; p0 = stop_cnt; d0 = fe_done_cnt; seen = 1'b0;
    fe_q.push_back(16'h0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fe_gnt) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || ctl_start !== 1'b1 || ctl_addr !== 16'h0000 || ctl_wr !== 1'b0) begin
      failures++; $display("FAIL cold_start: gnt=%0b start=%0b addr=%h wr=%0b required 1 1 0000 0",
                           seen, ctl_start, ctl_addr, ctl_wr);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ctl_beat) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || ctl_stop !== 1'b1) begin
      failures++; $display("FAIL cold_stop_with_beat: beat=%0b stop=%0b required 1 1", seen, ctl_stop);
    end
    @(negedge clk);
    checks++;
    if (fe_done !== 1'b1) begin
      failures++; $display("FAIL cold_done_latency: fe_done=%0b required 1", fe_done);
    end
    wait_quiet(60, ok);
    checks++;
    if (!ok || start_cnt - s0 != 1 || stop_cnt - p0 != 1 || fe_done_cnt - d0 != 1) begin
      failures++; $display("FAIL cold_counts: ok=%0b starts=%0d stops=%0d dones=%0d required 1 1 1 1",
                           ok, start_cnt - s0, stop_cnt - p0, fe_done_cnt - d0);
    end
  endtask

  task automatic test_seq_stream();
    int s0, p0, d0;
    bit ok;
    s0 = start_cnt; p0 = stop_cnt; d0 = fe_done_cnt;
    fe_q.push_back(16'h0010); fe_q.push_back(16'h0012); fe_q.push_back(16'h0014);
    wait_quiet(100, ok);
    checks++;
    if (!ok || start_cnt - s0 != 1 || fe_done_cnt - d0 != 3) begin
      failures++; $display("FAIL seq_stream: ok=%0b starts=%0d dones=%0d required 1 1 3",
                           ok, start_cnt - s0, fe_done_cnt - d0);
    end
    checks++;
    if (stop_cnt - p0 != 1 || beats_at_stop != 3) begin
      failures++; $display("FAIL seq_stop: stops=%0d beats_at_stop=%0d required 1 3",
                           stop_cnt - p0, beats_at_stop);
    end
  endtask

  task automatic test_miss_redirect();
    int s0, p0, g;
    bit ok;
    s0 = start_cnt; p0 = stop_cnt; g = 0;
    fe_q.push_back(16'h0010); fe_q.push_back(16'h0100);
    for (int i = 0; i < 100 && g < 2; i++) begin
      @(negedge clk);
      if (fe_gnt) begin
        g++;
        checks++;
        if (ctl_start !== 1'b1) begin
          failures++; $display("FAIL miss_gnt_in_busy: fe_gnt without start, grant #%0d", g);
        end
      end
    end
    wait_quiet(100, ok);
    checks++;
    if (!ok || g != 2 || start_cnt - s0 != 2 || stop_cnt - p0 != 2 || last_start_addr !== 16'h0100) begin
      failures++; $display("FAIL miss_redirect: ok=%0b gnts=%0d starts=%0d stops=%0d addr=%h required 1 2 2 2 0100",
                           ok, g, start_cnt - s0, stop_cnt - p0, last_start_addr);
    end
  endtask

  task automatic test_starvation();
    int lg, l0, f0;
    bit seen, ok;
    lg = 0; seen = 1'b0; l0 = ls_done_cnt; f0 = fe_done_cnt;
    for (int i = 0; i < 8; i++) ls_q.push_back({1'b0, 16'h0200 + 16'(2 * i)});
    fe_q.push_back(16'h0400);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ls_gnt) lg++;
      if (fe_gnt) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || lg != 4) begin
      failures++; $display("FAIL starve_ls_grants: fe_seen=%0b ls_grants=%0d required 1 4", seen, lg);
    end
    checks++;
    if (ctl_start !== 1'b1 || ctl_addr !== 16'h0400 || ctl_wr !== 1'b0) begin
      failures++; $display("FAIL starve_fe_start: start=%0b addr=%h wr=%0b required 1 0400 0",
                           ctl_start, ctl_addr, ctl_wr);
    end
    @(negedge clk);
    checks++;
    if (ctl_owner !== 1'b0) begin
      failures++; $display("FAIL starve_owner: owner=%0b required 0", ctl_owner);
    end
    wait_quiet(300, ok);
    checks++;
    if (!ok || ls_done_cnt - l0 != 8 || fe_done_cnt - f0 != 1) begin
      failures++; $display("FAIL starve_dones: ok=%0b ls=%0d fe=%0d required 1 8 1",
                           ok, ls_done_cnt - l0, fe_done_cnt - f0);
    end
  endtask

  task automatic test_dir_miss();
    int p0;
    bit seen, ok;
    p0 = stop_cnt; seen = 1'b0;
    fe_q.push_back(16'h0020);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fe_gnt) begin seen = 1'b1; break; end
    end
    ls_q.push_back({1'b1, 16'h0022});
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ls_gnt) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || ctl_start !== 1'b1 || ctl_wr !== 1'b1 || ctl_addr !== 16'h0022) begin
      failures++; $display("FAIL dir_miss_start: gnt=%0b start=%0b wr=%0b addr=%h required 1 1 1 0022",
                           seen, ctl_start, ctl_wr, ctl_addr);
    end
    @(negedge clk);
    checks++;
    if (ctl_wr !== 1'b1 || ctl_owner !== 1'b1 || ctl_addr !== 16'h0022) begin
      failures++; $display("FAIL dir_miss_hold: wr=%0b owner=%0b addr=%h required 1 1 0022",
                           ctl_wr, ctl_owner, ctl_addr);
    end
    wait_quiet(100, ok);
    checks++;
    if (!ok || stop_cnt - p0 != 2) begin
      failures++; $display("FAIL dir_miss_stops: ok=%0b stops=%0d required 1 2", ok, stop_cnt - p0);
    end
  endtask

  task automatic test_wrap_reset();
    int s0, d0;
    bit seen, ok;
    s0 = start_cnt; d0 = fe_done_cnt;
    fe_q.push_back(16'hFFFE); fe_q.push_back(16'h0000);
    wait_quiet(100, ok);
    checks++;
    if (!ok || start_cnt - s0 != 1 || fe_done_cnt - d0 != 2) begin
      failures++; $display("FAIL wrap_hit: ok=%0b starts=%0d dones=%0d required 1 1 2",
                           ok, start_cnt - s0, fe_done_cnt - d0);
    end
    // Reset in the middle of a stream, with requests still held.
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) fe_q.push_back(16'h0100 + 16'(2 * i));
    for (int i = 0; i < 20 && start_cnt == s0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fe_gnt, fe_done, ls_gnt, ls_done, ctl_start, ctl_wr, ctl_stop, ctl_owner, ctl_addr} !== '0) begin
      failures++; $display("FAIL reset_mid_busy: gnt=%0b start=%0b stop=%0b owner=%0b addr=%h required all 0",
                           fe_gnt, ctl_start, ctl_stop, ctl_owner, ctl_addr);
    end
    fe_q.delete(); ls_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl_stop !== 1'b0 || ctl_addr !== '0 || ctl_owner !== 1'b0) begin
      failures++; $display("FAIL reset_release: stop=%0b addr=%h owner=%0b required 0", ctl_stop, ctl_addr, ctl_owner);
    end
    fe_q.push_back(16'h0031);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fe_gnt) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || ctl_start !== 1'b1 || ctl_addr !== 16'h0030) begin
      failures++; $display("FAIL post_reset_start: gnt=%0b start=%0b addr=%h required 1 1 0030",
                           seen, ctl_start, ctl_addr);
    end
    wait_quiet(60, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL post_reset_quiet: ok=%0b required 1", ok);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_cold_fetch();
    test_seq_stream();
    test_miss_redirect();
    test_starvation();
    test_dir_miss();
    test_wrap_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
